// File: rtl/port_rst_arb.sv
// rtl/port_rst_arb.sv - round-robin arbiter sequencing one per-port soft reset at a time
// Each grant: hold rstn_port low HOLD_CYC cycles, settle SETTLE_CYC cycles, then 4-phase ack.
module port_rst_arb #(
  parameter int N_REQ      = 4,
  parameter int HOLD_CYC   = 64,
  parameter int SETTLE_CYC = 128
) (
  input  logic                     sys_clk,
  input  logic                     arstn,
  input  logic                     sys_ready,
  input  logic [N_REQ-1:0]         rst_req,
  output logic [N_REQ-1:0]         rst_ack,
  output logic [N_REQ-1:0]         rstn_port,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] cur_id
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int MAXC = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef logic [IDW-1:0] id_t;
  typedef logic [CW-1:0]  cnt_t;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    HOLD   = 4'b0010,
    SETTLE = 4'b0100,
    ACK    = 4'b1000
  } state_t;

  state_t state;
  cnt_t   cnt;
  id_t    ptr;
  id_t    grant;
  id_t    next_ptr;
  logic   found;
  int     s;

  // First requester at or above ptr, wrapping past N_REQ-1 back to 0.
  always_comb begin
    grant = ptr;
    found = 1'b0;
    s     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      s = int'(ptr) + i;
      if (s >= N_REQ) s = s - N_REQ;
      if (!found && rst_req[id_t'(s)]) begin
        grant = id_t'(s);
        found = 1'b1;
      end
    end
  end

  assign next_ptr = (cur_id == id_t'(N_REQ - 1)) ? '0 : cur_id + id_t'(1);

  always_ff @(posedge sys_clk or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      cur_id    <= '0;
      rstn_port <= '1;
      rst_ack   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sys_ready && found) begin
            state            <= HOLD;
            cur_id           <= grant;
            rstn_port[grant] <= 1'b0;
            cnt              <= '0;
            busy             <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt == cnt_t'(HOLD_CYC - 1)) begin
            state     <= SETTLE;
            rstn_port <= '1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        SETTLE: begin
          if (cnt == cnt_t'(SETTLE_CYC - 1)) begin
            state           <= ACK;
            rst_ack[cur_id] <= 1'b1;
            cnt             <= '0;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        ACK: begin
          // Handshake closes only when the granted requester lets go.
          if (!rst_req[cur_id]) begin
            state   <= IDLE;
            rst_ack <= '0;
            ptr     <= next_ptr;
            busy    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          rstn_port <= '1;
          rst_ack   <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
